traffic_phase_ctrl: RTL

//  Timed multi-approach traffic phase controller, clk_main domain. Successor to the single-light cycler.

---
 rtl/traffic_pkg.sv | 45 ++++
 rtl/dwell_timer.sv | 34 +++
 rtl/traffic_phase_ctrl.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic phase controller: lamp codes, phase states, dwell lookup.
// FLASH_MODE_EN adds the night-flash state.
package traffic_pkg;

    localparam logic [1:0] LT_GREEN  = 2'b00;
    localparam logic [1:0] LT_YELLOW = 2'b01;
    localparam logic [1:0] LT_RED    = 2'b10;
    localparam logic [1:0] LT_DARK   = 2'b11;

`ifdef FLASH_MODE_EN
    typedef enum logic [2:0] {
        StGreen,
        StYellow,
        StAllRed,
        StPedWalk,
        StFlash
    } state_e;
`else
    typedef enum logic [2:0] {
        StGreen,
        StYellow,
        StAllRed,
        StPedWalk
    } state_e;
`endif

    // Dwell length in cycles for a state; the flash state takes the default arm.
    function automatic int unsigned dwell_sel(
        input state_e      st,
        input int unsigned green_cyc,
        input int unsigned yellow_cyc,
        input int unsigned allred_cyc,
        input int unsigned ped_cyc,
        input int unsigned flash_half
    );
        case (st)
            StGreen:   return green_cyc;
            StYellow:  return yellow_cyc;
            StAllRed:  return allred_cyc;
            StPedWalk: return ped_cyc;
            default:   return flash_half;
        endcase
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Down-counting dwell timer: loads a value, decrements to zero and holds there.
module dwell_timer #(
    parameter int unsigned      CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] value_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Round-robin multi-approach traffic phase controller with all-red clearance and pedestrian walk.
// Optional night flash mode is enabled by defining FLASH_MODE_EN.
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int unsigned N_APPR     = 2,
    parameter int unsigned CNT_W      = 8,
    parameter int unsigned GREEN_CYC  = 20,
    parameter int unsigned YELLOW_CYC = 4,
    parameter int unsigned ALLRED_CYC = 2,
    parameter int unsigned PED_CYC    = 10,
    parameter int unsigned FLASH_HALF = 8,
    localparam int unsigned IDX_W     = $clog2(N_APPR)
) (
    input  logic                  clk_main,
    input  logic                  rst_main,
    input  logic                  ped_req,
`ifdef FLASH_MODE_EN
    input  logic                  flash_mode,
`endif
    output logic [2*N_APPR-1:0]   light,
    output logic [IDX_W-1:0]      active_idx,
    output logic                  ped_ack,
    output logic                  ped_walk
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_APPR - 1);
    localparam logic [CNT_W-1:0] GREEN_LD = CNT_W'(GREEN_CYC - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d, idx_next;
    logic             pend_q, pend_d;
    logic             ack_q, ack_d;
    logic             dwell_zero;
    logic             dwell_load, dwell_reload;
    logic [CNT_W-1:0] dwell_value;
`ifdef FLASH_MODE_EN
    logic             flash_dark_q, flash_dark_d;
    logic             from_flash_q, from_flash_d;
`endif

    assign idx_next = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        dwell_reload = 1'b0;
`ifdef FLASH_MODE_EN
        flash_dark_d = flash_dark_q;
        from_flash_d = from_flash_q;
`endif
        unique case (state_q)
            StGreen: begin
                if (dwell_zero) state_d = StYellow;
            end
            StYellow: begin
                if (dwell_zero) state_d = StAllRed;
            end
            StAllRed: begin
                if (dwell_zero) begin
`ifdef FLASH_MODE_EN
                    if (flash_mode) begin
                        state_d      = StFlash;
                        flash_dark_d = 1'b0;
                    end else if (from_flash_q) begin
                        // Leaving flash restarts the rotation from approach 0.
                        state_d      = StGreen;
                        idx_d        = '0;
                        from_flash_d = 1'b0;
                    end else
`endif
                    if (pend_q) begin
                        state_d = StPedWalk;
                    end else begin
                        state_d = StGreen;
                        idx_d   = idx_next;
                    end
                end
            end
            StPedWalk: begin
                if (dwell_zero) begin
                    state_d = StGreen;
                    idx_d   = idx_next;
                end
            end
`ifdef FLASH_MODE_EN
            StFlash: begin
                if (!flash_mode) begin
                    state_d      = StAllRed;
                    from_flash_d = 1'b1;
                end else if (dwell_zero) begin
                    flash_dark_d = ~flash_dark_q;
                    dwell_reload = 1'b1;
                end
            end
`endif
            default: begin
                state_d = StGreen;
                idx_d   = '0;
            end
        endcase
    end

    assign dwell_load  = dwell_reload || (state_d != state_q);
    assign dwell_value = CNT_W'(dwell_sel(state_d, GREEN_CYC, YELLOW_CYC, ALLRED_CYC, PED_CYC,
                                          FLASH_HALF) - 1);

    // Walk entry clears the pending request; a request seen on that edge is dropped by design
    // since pend is still set then, so the next free cycle re-latches it.
    always_comb begin
        pend_d = pend_q;
        ack_d  = 1'b0;
        if (state_d == StPedWalk && state_q != StPedWalk) begin
            pend_d = 1'b0;
        end else if (ped_req && !pend_q) begin
            pend_d = 1'b1;
            ack_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_main or posedge rst_main) begin
        if (rst_main) begin
            state_q      <= StGreen;
            idx_q        <= '0;
            pend_q       <= 1'b0;
            ack_q        <= 1'b0;
`ifdef FLASH_MODE_EN
            flash_dark_q <= 1'b0;
            from_flash_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            pend_q       <= pend_d;
            ack_q        <= ack_d;
`ifdef FLASH_MODE_EN
            flash_dark_q <= flash_dark_d;
            from_flash_q <= from_flash_d;
`endif
        end
    end

    dwell_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (GREEN_LD)
    ) u_dwell_timer (
        .clk_i   (clk_main),
        .rst_i   (rst_main),
        .load_i  (dwell_load),
        .value_i (dwell_value),
        .zero_o  (dwell_zero)
    );

    always_comb begin
        light = '0;
        for (int unsigned i = 0; i < N_APPR; i++) begin
            light[2*i +: 2] = LT_RED;
            if (idx_q == IDX_W'(i) && state_q == StGreen) begin
                light[2*i +: 2] = LT_GREEN;
            end else if (idx_q == IDX_W'(i) && state_q == StYellow) begin
                light[2*i +: 2] = LT_YELLOW;
            end
`ifdef FLASH_MODE_EN
            if (state_q == StFlash) begin
                light[2*i +: 2] = flash_dark_q ? LT_DARK : LT_YELLOW;
            end
`endif
        end
    end

    assign active_idx = idx_q;
    assign ped_ack    = ack_q;
    assign ped_walk   = (state_q == StPedWalk);

endmodule
